// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared core definitions: datapath width, the register-file write request
//   record used by the write-port arbiter, and the arbiter's starvation-guard
//   state encoding.
// ----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   // One pending register-file write: destination register plus data.
   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } rf_wr_req_t;

   // Starvation guard: IDLE (no blocked head), COUNT (head blocked, counting),
   // FORCE (head takes the port from WB, pipeline frozen).
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_FORCE = 2'd2
   } starve_state_t;

   // One-hot decode of a register index into a 32-bit register mask.
   function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
      return 32'd1 << rd;
   endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// ----------------------------------------------------------------------------
// rf_wr_fifo
//   DEPTH-entry synchronous FIFO of rf_wr_req_t holding side-requester writes
//   until the register-file port is free. Exposes the head entry, full/empty,
//   a per-slot valid vector and the per-slot destination registers so the
//   arbiter can build the pending-rd mask.
//
// Parameters
//   DEPTH       number of entries (power of 2, >= 2)
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active-low
//   push_i      write din_i at the tail (ignored while full)
//   pop_i       drop the head entry (ignored while empty)
//   din_i       entry to push
//   head_o      current head entry (undefined while empty)
//   full_o      all DEPTH entries occupied
//   empty_o     no entries occupied
//   valid_o     per-slot occupancy, indexed by physical slot
//   rd_vec_o    per-slot destination register, slot i at [5*i +: 5]
// ----------------------------------------------------------------------------
module rf_wr_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push_i,
   input  logic               pop_i,
   input  rf_wr_req_t         din_i,
   output rf_wr_req_t         head_o,
   output logic               full_o,
   output logic               empty_o,
   output logic [DEPTH-1:0]   valid_o,
   output logic [5*DEPTH-1:0] rd_vec_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   rf_wr_req_t        r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [DEPTH-1:0]  r_valid;

   logic              w_push;
   logic              w_pop;

   assign full_o  = (r_count == CW'(DEPTH));
   assign empty_o = (r_count == '0);

   // A push is refused while full even if the head pops in the same cycle.
   assign w_push = push_i & ~full_o;
   assign w_pop  = pop_i  & ~empty_o;

   // Pointers are PW bits wide, so they wrap modulo DEPTH by overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr          <= r_wr_ptr + 1'b1;
            r_valid[r_wr_ptr] <= 1'b1;
         end
         // Push and pop never hit the same slot: that would need a full FIFO
         // (push refused) or an empty one (pop refused).
         if (w_pop) begin
            r_rd_ptr          <= r_rd_ptr + 1'b1;
            r_valid[r_rd_ptr] <= 1'b0;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; occupancy is tracked by r_valid/r_count, so
   // stale contents are never observed and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din_i;
      end
   end

   assign head_o  = r_mem[r_rd_ptr];
   assign valid_o = r_valid;

   always_comb begin
      rd_vec_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_vec_o[5*i +: 5] = r_mem[i].rd;
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// ----------------------------------------------------------------------------
// rf_write_arbiter
//   Shares the register file's single write port between the in-order WB
//   stage and a long-latency side requester (mul/div). Side results are
//   queued in rf_wr_fifo and drained on cycles where WB does not write. The
//   registers targeted by queued writes are exported as pend_mask_o so the
//   hazard unit can hold dependent instructions.
//
//   Optional feature macro: RF_ARB_STARVE_EN
//     When defined, a starvation guard counts cycles the FIFO head is blocked
//     by WB; after STARVE_LIMIT such cycles it raises stall_o and gives the
//     port to the head for one write. When undefined, WB always wins and
//     stall_o is tied low.
//
// Parameters
//   DEPTH         side FIFO entries (power of 2, >= 2)
//   STARVE_LIMIT  blocked cycles before a forced drain (RF_ARB_STARVE_EN only)
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active-low
//   wb_we_i       WB-stage write enable
//   wb_rd_i       WB-stage destination register
//   wb_data_i     WB-stage write data
//   side_valid_i  side request valid
//   side_ready_o  side request accepted when valid & ready
//   side_rd_i     side destination register
//   side_data_i   side write data
//   rf_we_o       register file write enable
//   rf_rd_o       register file write address
//   rf_wdata_o    register file write data
//   pend_mask_o   bit r set while a queued side write targets xr
//   stall_o       pipeline freeze request to the hazard unit
// ----------------------------------------------------------------------------
module rf_write_arbiter
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4
`ifdef RF_ARB_STARVE_EN
   ,
   parameter int STARVE_LIMIT = 8
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_we_i,
   input  logic [4:0]      wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            side_valid_i,
   output logic            side_ready_o,
   input  logic [4:0]      side_rd_i,
   input  logic [XLEN-1:0] side_data_i,
   output logic            rf_we_o,
   output logic [4:0]      rf_rd_o,
   output logic [XLEN-1:0] rf_wdata_o,
   output logic [31:0]     pend_mask_o,
   output logic            stall_o
);

   rf_wr_req_t         w_head;
   rf_wr_req_t         w_side_req;
   logic               w_full;
   logic               w_empty;
   logic [DEPTH-1:0]   w_valid;
   logic [5*DEPTH-1:0] w_rd_vec;

   logic               w_wb_req;
   logic               w_force;
   logic               w_grant_wb;
   logic               w_push;
   logic               w_pop;

   // ---------------------------------------------------------------------
   // Side request acceptance
   // ---------------------------------------------------------------------
   // Ready is held low during reset so nothing is handshaken while the FIFO
   // is being cleared.
   assign side_ready_o = rst & ~w_full;

   // Writes to x0 are acknowledged but never queued.
   assign w_push = side_valid_i & side_ready_o & (side_rd_i != 5'd0);

   assign w_side_req.rd   = side_rd_i;
   assign w_side_req.data = side_data_i;

   // ---------------------------------------------------------------------
   // Port mux
   // ---------------------------------------------------------------------
   // WB writes to x0 are architectural no-ops, so they neither use the port
   // nor block the FIFO from draining.
   assign w_wb_req   = wb_we_i & (wb_rd_i != 5'd0);
   assign w_grant_wb = w_wb_req & ~w_force;
   assign w_pop      = rst & ~w_empty & ~w_grant_wb;

   assign rf_we_o    = rst & (w_grant_wb | ~w_empty);
   assign rf_rd_o    = w_grant_wb ? wb_rd_i   : w_head.rd;
   assign rf_wdata_o = w_grant_wb ? wb_data_i : w_head.data;

   // ---------------------------------------------------------------------
   // Side FIFO
   // ---------------------------------------------------------------------
   rf_wr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (w_push),
      .pop_i    (w_pop),
      .din_i    (w_side_req),
      .head_o   (w_head),
      .full_o   (w_full),
      .empty_o  (w_empty),
      .valid_o  (w_valid),
      .rd_vec_o (w_rd_vec)
   );

   // ---------------------------------------------------------------------
   // Pending-rd mask
   // ---------------------------------------------------------------------
   // Built only from FIFO state registers, so it changes only at clock edges
   // (or asynchronously to zero on reset) and behaves as a registered output.
   // NOTE: every variable written in an always_comb block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      pend_mask_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_valid[i]) begin
            pend_mask_o = pend_mask_o | rd_onehot(w_rd_vec[5*i +: 5]);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Starvation guard
   // ---------------------------------------------------------------------
`ifdef RF_ARB_STARVE_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;

   starve_state_t      r_state;
   starve_state_t      w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_blocked;

   // The head is blocked whenever something is queued but not popped.
   assign w_blocked = ~w_empty & ~w_pop;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its peers, independent of block order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE, ST_COUNT: begin
            if (w_blocked) begin
               // The block seen while the count sits at LIMIT-1 is the one
               // that trips the guard.
               if (r_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                  w_state_nxt = ST_FORCE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ST_COUNT;
                  w_cnt_nxt   = r_cnt + 1'b1;
               end
            end else begin
               // Either the head popped or the FIFO is empty.
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         ST_FORCE: begin
            // The head owns the port here, so it pops at this edge.
            if (w_pop || w_empty) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_force = (r_state == ST_FORCE);
   assign stall_o = w_force;
`else
   assign w_force = 1'b0;
   assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
   import riscv_pkg::*;

   logic            clk;
   logic            rst;
   logic            wb_we_i;
   logic [4:0]      wb_rd_i;
   logic [XLEN-1:0] wb_data_i;
   logic            side_valid_i;
   logic            side_ready_o;
   logic [4:0]      side_rd_i;
   logic [XLEN-1:0] side_data_i;
   logic            rf_we_o;
   logic [4:0]      rf_rd_o;
   logic [XLEN-1:0] rf_wdata_o;
   logic [31:0]     pend_mask_o;
   logic            stall_o;

   int total = 0;
   int bad   = 0;

   rf_wr_req_t exp_q[$];

   rf_write_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .wb_we_i      (wb_we_i),
      .wb_rd_i      (wb_rd_i),
      .wb_data_i    (wb_data_i),
      .side_valid_i (side_valid_i),
      .side_ready_o (side_ready_o),
      .side_rd_i    (side_rd_i),
      .side_data_i  (side_data_i),
      .rf_we_o      (rf_we_o),
      .rf_rd_o      (rf_rd_o),
      .rf_wdata_o   (rf_wdata_o),
      .pend_mask_o  (pend_mask_o),
      .stall_o      (stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input logic [4:0] rd, input logic [XLEN-1:0] data);
      rf_wr_req_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic side_drive(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] data);
      side_valid_i = v;
      side_rd_i    = rd;
      side_data_i  = data;
   endtask

   task automatic wb_drive(input logic we, input logic [4:0] rd, input logic [XLEN-1:0] data);
      wb_we_i   = we;
      wb_rd_i   = rd;
      wb_data_i = data;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: every register-file write must match the scoreboard head.
   always @(negedge clk) begin
      if (rst && rf_we_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {27'd0, rf_rd_o, rf_wdata_o}, 64'd0);
         end else begin
            rf_wr_req_t e;
            e = exp_q.pop_front();
            check("rf_write", {27'd0, rf_rd_o, rf_wdata_o}, {27'd0, e.rd, e.data});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Test 1: reset held with requests present.
      rst = 1'b0;
      wb_drive(1'b1, 5'd3, 32'h0000_0033);
      side_drive(1'b1, 5'd5, 32'h0000_0055);
      #12;
      check("t1_ready_in_reset", side_ready_o, 0);
      check("t1_we_in_reset",    rf_we_o, 0);
      check("t1_mask_in_reset",  pend_mask_o, 0);
      check("t1_stall_in_reset", stall_o, 0);
      tick();
      wb_drive(1'b0, 5'd0, '0);
      side_drive(1'b0, 5'd0, '0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("t1_mask_after_reset", pend_mask_o, 0);

      // Test 2: single side write with idle WB.
      tick();
      side_drive(1'b1, 5'd5, 32'hDEAD_BEEF);
      exp_push(5'd5, 32'hDEAD_BEEF);
      @(negedge clk);
      check("t2_ready",       side_ready_o, 1);
      check("t2_no_write_c0", rf_we_o, 0);
      check("t2_mask_c0",     pend_mask_o, 0);
      tick();
      side_drive(1'b0, 5'd0, '0);
      @(negedge clk);
      check("t2_write_c1", rf_we_o, 1);
      check("t2_mask_c1",  pend_mask_o, 32'h0000_0020);
      tick();
      @(negedge clk);
      check("t2_mask_c2",  pend_mask_o, 0);
      check("t2_idle_c2",  rf_we_o, 0);

      // Back-to-back pushes with idle WB: push and pop overlap each cycle.
      for (int i = 0; i < 3; i++) begin
         tick();
         side_drive(1'b1, 5'(8 + i), 32'h0000_0800 + 32'(i));
         exp_push(5'(8 + i), 32'h0000_0800 + 32'(i));
         @(negedge clk);
         if (i == 2) check("stream_mask", pend_mask_o, 32'h0000_0200);
      end
      tick();
      side_drive(1'b0, 5'd0, '0);
      wait_drain();

      // Test 3: WB busy, fill the FIFO, then drain in order.
      for (int i = 1; i <= 4; i++) begin
         tick();
         wb_drive(1'b1, 5'(10 + i), 32'h0000_1000 + 32'(i));
         side_drive(1'b1, 5'(i), 32'h0000_0100 + 32'(i));
         exp_push(5'(10 + i), 32'h0000_1000 + 32'(i));
         @(negedge clk);
         check("t3_ready_fill", side_ready_o, 1);
      end
      tick();
      wb_drive(1'b1, 5'd15, 32'h0000_1005);
      side_drive(1'b1, 5'd5, 32'h0000_0105);
      exp_push(5'd15, 32'h0000_1005);
      @(negedge clk);
      check("t3_ready_full", side_ready_o, 0);
      check("t3_mask_full",  pend_mask_o, 32'h0000_001E);
      tick();
      wb_drive(1'b0, 5'd0, '0);
      side_drive(1'b0, 5'd0, '0);
      for (int i = 1; i <= 4; i++) exp_push(5'(i), 32'h0000_0100 + 32'(i));
      wait_drain();
      check("t3_mask_empty", pend_mask_o, 0);

      // WB write to x0 does not block draining and is never issued.
      tick();
      side_drive(1'b1, 5'd7, 32'h0000_0077);
      exp_push(5'd7, 32'h0000_0077);
      tick();
      side_drive(1'b0, 5'd0, '0);
      wb_drive(1'b1, 5'd0, 32'h0000_0BAD);
      @(negedge clk);
      check("x0wb_drain_we", rf_we_o, 1);
      check("x0wb_drain_rd", rf_rd_o, 5'd7);
      tick();
      @(negedge clk);
      check("x0wb_no_write", rf_we_o, 0);
      tick();
      wb_drive(1'b0, 5'd0, '0);

      // Test 4: side write to x0 is acked and dropped.
      tick();
      side_drive(1'b1, 5'd0, 32'h0000_005A);
      @(negedge clk);
      check("t4_ready", side_ready_o, 1);
      tick();
      side_drive(1'b0, 5'd0, '0);
      @(negedge clk);
      check("t4_mask_c1", pend_mask_o, 0);
      check("t4_we_c1",   rf_we_o, 0);
      tick();
      @(negedge clk);
      check("t4_we_c2",   rf_we_o, 0);

`ifdef RF_ARB_STARVE_EN
      // Test 5: WB writes continuously; one queued entry forces a drain.
      for (int i = 0; i <= 8; i++) begin
         tick();
         wb_drive(1'b1, 5'd20, 32'h0000_2000 + 32'(i));
         if (i == 0) side_drive(1'b1, 5'd6, 32'h0000_0066);
         else        side_drive(1'b0, 5'd0, '0);
         exp_push(5'd20, 32'h0000_2000 + 32'(i));
         @(negedge clk);
         check("t5_no_stall", stall_o, 0);
      end
      tick();
      wb_drive(1'b1, 5'd20, 32'h0000_2009);
      exp_push(5'd6, 32'h0000_0066);
      @(negedge clk);
      check("t5_stall_high", stall_o, 1);
      check("t5_forced_rd",  rf_rd_o, 5'd6);
      tick();
      exp_push(5'd20, 32'h0000_2009);
      @(negedge clk);
      check("t5_stall_low", stall_o, 0);
      tick();
      wb_drive(1'b0, 5'd0, '0);
      wait_drain();
`endif

      // Test 6: reset with three entries queued behind a busy WB.
      for (int i = 0; i < 3; i++) begin
         tick();
         wb_drive(1'b1, 5'd21, 32'h0000_3000 + 32'(i));
         side_drive(1'b1, 5'(11 + i), 32'h0000_0B00 + 32'(i));
         exp_push(5'd21, 32'h0000_3000 + 32'(i));
         @(negedge clk);
      end
      tick();
      side_drive(1'b0, 5'd0, '0);
      wb_drive(1'b1, 5'd21, 32'h0000_3003);
      exp_push(5'd21, 32'h0000_3003);
      @(negedge clk);
      check("t6_mask_queued", pend_mask_o, 32'h0000_3800);
      @(posedge clk);
      #2;
      rst = 1'b0;
      wb_drive(1'b0, 5'd0, '0);
      #1;
      check("t6_mask_reset",  pend_mask_o, 0);
      check("t6_ready_reset", side_ready_o, 0);
      check("t6_we_reset",    rf_we_o, 0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t6_no_stale_we", rf_we_o, 0);
         tick();
      end
      @(negedge clk);
      check("t6_mask_after", pend_mask_o, 0);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
